// File: rtl/token_step_controller.sv
// token_step_controller
// Animates a dice-driven move for two board tokens. The active token hops one
// tile every STEP_FRAMES frame ticks until the rolled count is used up. The
// controller then pulses done and reports a win when the token sits on
// LAST_TILE.
// Optional feature macro: BOUNCE_BACK_EN. When it is defined, an overshoot
// past LAST_TILE reverses direction. When it is undefined, the token clamps
// on LAST_TILE and the move ends early.
module token_step_controller #(
    parameter int STEP_FRAMES = 15,  // frame ticks per hop, 1..255
    parameter int LAST_TILE   = 9    // goal tile, 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       player_sel,
    input  logic [2:0] dice_val,
    output logic [3:0] tile_idx_p0,
    output logic [3:0] tile_idx_p1,
    output logic       busy,
    output logic       done,
    output logic       winner_valid,
    output logic       winner
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HOP_WAIT = 2'd1;
    localparam logic [1:0] STEP     = 2'd2;
    localparam logic [1:0] FINISH   = 2'd3;

    localparam logic [7:0] TICK_LAST = 8'(STEP_FRAMES - 1);
    localparam logic [3:0] GOAL      = 4'(LAST_TILE);

    logic [1:0] state;
    logic [7:0] tick_cnt;
    logic [2:0] remaining;
    logic       active;     // token being moved: 0 = P0, 1 = P1
    logic       dir_rev;    // 0 = forward, 1 = reverse (bounce-back only)

    logic       start_ok;
    logic [3:0] cur_tile;
    logic [3:0] step_tile;
    logic       step_rev;
    logic       step_stop;
    logic [2:0] step_remaining;

    // Only a legal roll that arrives in IDLE with no winner yet starts a move.
    assign start_ok = start && (dice_val != 3'd0) && (dice_val != 3'd7) && !winner_valid;
    assign cur_tile = active ? tile_idx_p1 : tile_idx_p0;

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

    // Work out the tile, direction and hop count that the next STEP will produce.
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        step_tile = cur_tile;
        step_rev  = dir_rev;
        step_stop = 1'b0;
        if (!dir_rev) begin
            if (cur_tile < GOAL) begin
                step_tile = cur_tile + 4'd1;
            end else begin
`ifdef BOUNCE_BACK_EN
                // Overshoot: turn around and use this hop walking back.
                step_rev  = 1'b1;
                step_tile = cur_tile - 4'd1;
`else
                // Overshoot: clamp on the goal and drop the rest of the roll.
                step_stop = 1'b1;
`endif
            end
        end else if (cur_tile != 4'd0) begin
            step_tile = cur_tile - 4'd1;
        end
        step_remaining = step_stop ? 3'd0 : (remaining - 3'd1);
    end

    // Move sequencing, tile registers and sticky win status.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, matching the hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= 8'd0;
            remaining    <= 3'd0;
            active       <= 1'b0;
            dir_rev      <= 1'b0;
            tile_idx_p0  <= 4'd0;
            tile_idx_p1  <= 4'd0;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= HOP_WAIT;
                        active    <= player_sel;
                        remaining <= dice_val;
                        tick_cnt  <= 8'd0;
                        dir_rev   <= 1'b0;
                    end
                end

                HOP_WAIT: begin
                    if (frame_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            state    <= STEP;
                            tick_cnt <= 8'd0;
                        end else begin
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end
                end

                STEP: begin
                    if (active) begin
                        tile_idx_p1 <= step_tile;
                    end else begin
                        tile_idx_p0 <= step_tile;
                    end
                    dir_rev   <= step_rev;
                    remaining <= step_remaining;
                    if (step_remaining == 3'd0) begin
                        state <= FINISH;
                        // Set the win here so winner_valid rises together with done.
                        if (step_tile == GOAL) begin
                            winner_valid <= 1'b1;
                            winner       <= active;
                        end
                    end else begin
                        state <= HOP_WAIT;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_token_step_controller.sv
// Self-checking bench for token_step_controller.
// Main instance: STEP_FRAMES=2 and LAST_TILE=9. A second instance uses
// STEP_FRAMES=1 to cover the frame_tick that coincides with start.
module tb_token_step_controller;

    localparam int SF   = 2;
    localparam int LAST = 9;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       player_sel;
    logic [2:0] dice_val;
    logic [3:0] tile_idx_p0;
    logic [3:0] tile_idx_p1;
    logic       busy;
    logic       done;
    logic       winner_valid;
    logic       winner;

    logic       f1_tick;
    logic       f1_start;
    logic       f1_ps;
    logic [2:0] f1_dice;
    logic [3:0] f1_p0;
    logic [3:0] f1_p1;
    logic       f1_busy;
    logic       f1_done;
    logic       f1_wv;
    logic       f1_win;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    token_step_controller #(.STEP_FRAMES(SF), .LAST_TILE(LAST)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .start        (start),
        .player_sel   (player_sel),
        .dice_val     (dice_val),
        .tile_idx_p0  (tile_idx_p0),
        .tile_idx_p1  (tile_idx_p1),
        .busy         (busy),
        .done         (done),
        .winner_valid (winner_valid),
        .winner       (winner)
    );

    token_step_controller #(.STEP_FRAMES(1), .LAST_TILE(LAST)) dut_f1 (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (f1_tick),
        .start        (f1_start),
        .player_sel   (f1_ps),
        .dice_val     (f1_dice),
        .tile_idx_p0  (f1_p0),
        .tile_idx_p1  (f1_p1),
        .busy         (f1_busy),
        .done         (f1_done),
        .winner_valid (f1_wv),
        .winner       (f1_win)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        start      = 1'b0;
        frame_tick = 1'b0;
        player_sel = 1'b0;
        dice_val   = 3'd0;
        tick_clk();
        tick_clk();
        reset = 1'b0;
    endtask

    logic [3:0] traj[$];

    // Start a move, then feed a tick every cycle until done. Records the tile values
    // the mover passes through and the win flags around done.
    task automatic run_move(input logic ps, input logic [2:0] dice, output bit seen,
                            output logic wv_before, output logic wv_at, output logic win_at);
        logic [3:0] last;
        seen      = 1'b0;
        wv_before = 1'b0;
        wv_at     = 1'b0;
        win_at    = 1'b0;
        traj.delete();
        last       = ps ? tile_idx_p1 : tile_idx_p0;
        start      = 1'b1;
        player_sel = ps;
        dice_val   = dice;
        frame_tick = 1'b0;
        tick_clk();
        start      = 1'b0;
        dice_val   = 3'd0;
        frame_tick = 1'b1;
        for (int n = 0; n < 200 && !seen; n++) begin
            wv_before = winner_valid;
            tick_clk();
            if ((ps ? tile_idx_p1 : tile_idx_p0) != last) begin
                last = ps ? tile_idx_p1 : tile_idx_p0;
                traj.push_back(last);
            end
            if (done) begin
                seen   = 1'b1;
                wv_at  = winner_valid;
                win_at = winner;
            end
        end
        frame_tick = 1'b0;
        check("move reached done", 32'(seen), 1);
        tick_clk();
    endtask

    // ---------------- reference model ----------------
    // Bookkeeping per move: ticks counted toward the next hop, hops left,
    // and whether this cycle performs the hop or announces completion.
    int m_tile[2];
    bit m_wv, m_win, m_moving, m_step_now, m_finish_now;
    int m_player, m_left, m_ticks, m_dir;

    task automatic model_reset();
        m_tile[0] = 0; m_tile[1] = 0;
        m_wv = 0; m_win = 0; m_moving = 0; m_step_now = 0; m_finish_now = 0;
        m_player = 0; m_left = 0; m_ticks = 0; m_dir = 1;
    endtask

    task automatic model_edge(input bit r, input bit st, input bit ps, input int dv, input bit tk);
        int t;
        if (r) begin
            model_reset();
        end else if (m_finish_now) begin
            m_finish_now = 0;
            m_moving     = 0;
        end else if (m_step_now) begin
            m_step_now = 0;
            t = m_tile[m_player];
            if (m_dir > 0 && t < LAST) begin
                t = t + 1;
            end else if (m_dir > 0) begin
`ifdef BOUNCE_BACK_EN
                m_dir = -1;
                t = t - 1;
`else
                m_left = 1;
`endif
            end else if (t > 0) begin
                t = t - 1;
            end
            m_left = m_left - 1;
            m_tile[m_player] = t;
            if (m_left == 0) begin
                m_finish_now = 1;
                if (t == LAST) begin
                    m_wv  = 1;
                    m_win = (m_player == 1);
                end
            end
        end else if (m_moving) begin
            if (tk) begin
                m_ticks++;
                if (m_ticks == SF) begin
                    m_ticks    = 0;
                    m_step_now = 1;
                end
            end
        end else if (st && dv >= 1 && dv <= 6 && !m_wv) begin
            m_moving = 1;
            m_player = ps ? 1 : 0;
            m_left   = dv;
            m_ticks  = 0;
            m_dir    = 1;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       start;
        logic       ps;
        logic [2:0] dice;
        logic       tick;
        logic       busy;
        logic       done;
        logic [3:0] p0;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit         seen;
        logic       wvb, wva, wna;
        logic [3:0] exp_traj[$];
        bit         exp_wv;
        int         dv;
        bit         r, st, ps, tk;

        reset = 1'b1; start = 1'b0; frame_tick = 1'b0; player_sel = 1'b0; dice_val = 3'd0;
        f1_tick = 1'b0; f1_start = 1'b0; f1_ps = 1'b0; f1_dice = 3'd0;

        // P0 rolls 3 with a tick every cycle; illegal and mid-move starts are ignored.
        vecs[0]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[6]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[8]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 4'd3};
        vecs[10] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 4'd3};
        vecs[11] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd3};

        // Reset state.
        do_reset();
        check("reset p0", 32'(tile_idx_p0), 0);
        check("reset p1", 32'(tile_idx_p1), 0);
        check("reset busy/done", 32'({busy, done}), 0);
        check("reset winner", 32'({winner_valid, winner}), 0);
        check("reset f1 outputs", 32'({f1_p0, f1_p1, f1_busy, f1_done, f1_wv, f1_win}), 0);

        for (int i = 0; i < 12; i++) begin
            start      = vecs[i].start;
            player_sel = vecs[i].ps;
            dice_val   = vecs[i].dice;
            frame_tick = vecs[i].tick;
            tick_clk();
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
            check($sformatf("vec%0d p0", i), 32'(tile_idx_p0), 32'(vecs[i].p0));
            check($sformatf("vec%0d p1/win", i), 32'({tile_idx_p1, winner_valid}), 0);
        end
        start = 1'b0; frame_tick = 1'b0;

        // P0 reaches the goal exactly: 6, 1, then 2 from tile 7.
        do_reset();
        run_move(1'b0, 3'd6, seen, wvb, wva, wna);
        check("p0 after 6", 32'(tile_idx_p0), 6);
        run_move(1'b0, 3'd1, seen, wvb, wva, wna);
        check("p0 after 7", 32'(tile_idx_p0), 7);
        run_move(1'b0, 3'd2, seen, wvb, wva, wna);
        check("win p0 tile", 32'(tile_idx_p0), 9);
        check("win not before done", 32'(wvb), 0);
        check("win valid at done", 32'(wva), 1);
        check("winner at done", 32'(wna), 0);
        check("win p1 untouched", 32'(tile_idx_p1), 0);
        start = 1'b1; player_sel = 1'b1; dice_val = 3'd4; frame_tick = 1'b1;
        tick_clk();
        start = 1'b0; dice_val = 3'd0;
        for (int i = 0; i < 4; i++) tick_clk();
        frame_tick = 1'b0;
        check("post-win start busy", 32'(busy), 0);
        check("post-win start p1", 32'(tile_idx_p1), 0);
        check("post-win sticky", 32'({winner_valid, winner}), 32'(2'b10));

        // P1 at tile 8 rolls 4 (overshoot).
        do_reset();
        run_move(1'b1, 3'd6, seen, wvb, wva, wna);
        run_move(1'b1, 3'd2, seen, wvb, wva, wna);
        check("p1 at 8", 32'(tile_idx_p1), 8);
        run_move(1'b1, 3'd4, seen, wvb, wva, wna);
`ifdef BOUNCE_BACK_EN
        exp_traj = '{4'd9, 4'd8, 4'd7, 4'd6};
        exp_wv   = 1'b0;
`else
        exp_traj = '{4'd9};
        exp_wv   = 1'b1;
        check("overshoot winner", 32'(wna), 1);
`endif
        check("overshoot hop count", traj.size(), exp_traj.size());
        for (int i = 0; i < exp_traj.size() && i < traj.size(); i++)
            check($sformatf("overshoot tile[%0d]", i), 32'(traj[i]), 32'(exp_traj[i]));
        check("overshoot win flag", 32'(wva), 32'(exp_wv));
        check("overshoot p0 held", 32'(tile_idx_p0), 0);

        // Reset during HOP_WAIT of a 6-roll.
        do_reset();
        run_move(1'b0, 3'd2, seen, wvb, wva, wna);
        start = 1'b1; player_sel = 1'b1; dice_val = 3'd6; frame_tick = 1'b0;
        tick_clk();
        start = 1'b0; dice_val = 3'd0;
        check("abort accepted", 32'(busy), 1);
        frame_tick = 1'b1;
        for (int i = 0; i < 4; i++) tick_clk();
        check("abort pre tiles", 32'({tile_idx_p0, tile_idx_p1, busy}), 32'({4'd2, 4'd1, 1'b1}));
        reset = 1'b1;
        tick_clk();
        reset = 1'b0;
        check("abort tiles", 32'({tile_idx_p0, tile_idx_p1}), 0);
        check("abort busy/done", 32'({busy, done}), 0);
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            check($sformatf("abort quiet%0d", i), 32'({busy, done}), 0);
        end
        run_move(1'b1, 3'd1, seen, wvb, wva, wna);
        check("restart p1", 32'(tile_idx_p1), 1);

        // STEP_FRAMES=1: the tick that coincides with start is not counted.
        f1_start = 1'b1; f1_ps = 1'b0; f1_dice = 3'd2; f1_tick = 1'b1;
        tick_clk();
        f1_start = 1'b0; f1_dice = 3'd0; f1_tick = 1'b0;
        check("f1 accepted", 32'({f1_busy, f1_p0}), 32'({1'b1, 4'd0}));
        tick_clk();
        check("f1 no hop c1", 32'(f1_p0), 0);
        tick_clk();
        check("f1 no hop c2", 32'(f1_p0), 0);
        f1_tick = 1'b1;
        tick_clk();
        f1_tick = 1'b0;
        check("f1 no hop c3", 32'(f1_p0), 0);
        tick_clk();
        check("f1 first hop", 32'({f1_p0, f1_done}), 32'({4'd1, 1'b0}));
        f1_tick = 1'b1;
        tick_clk();
        f1_tick = 1'b0;
        tick_clk();
        check("f1 second hop done", 32'({f1_p0, f1_done, f1_busy}), 32'({4'd2, 1'b1, 1'b1}));
        tick_clk();
        check("f1 idle", 32'({f1_busy, f1_done}), 0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 119) == 0);
            st = ($urandom_range(0, 5) == 0);
            ps = 1'($urandom_range(0, 1));
            dv = int'($urandom_range(0, 7));
            tk = 1'($urandom_range(0, 1));
            reset      = r;
            start      = st;
            player_sel = ps;
            dice_val   = 3'(dv);
            frame_tick = tk;
            model_edge(r, st, ps, dv, tk);
            tick_clk();
            check($sformatf("rand c%0d {p0,p1,busy,done,wv,win}", c),
                  32'({tile_idx_p0, tile_idx_p1, busy, done, winner_valid, winner}),
                  32'({4'(m_tile[0]), 4'(m_tile[1]), m_moving, m_finish_now, m_wv, m_win}));
        end
        reset = 1'b0; start = 1'b0; frame_tick = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/token_step_controller.md
# token_step_controller

Animates a dice-driven board move for two player tokens, advancing the active token one tile at a time on VGA frame ticks until the rolled count is consumed. Sits directly upstream of the tile-to-pixel position mapping stage: its `tile_idx_p0` and `tile_idx_p1` outputs (0–9) feed that stage to place each token sprite. Takes the dice result from the dice-recognition/game-control logic and reports move completion and win status back to it.

## Interface
- `STEP_FRAMES`, default 15: frame ticks per one-tile hop; legal range 1–255.
- `LAST_TILE`, default 9: goal tile index; legal range 1–15.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per displayed frame.
- `start` in 1: one-cycle move request.
- `player_sel` in 1: token to move (0 = P0, 1 = P1); sampled with `start`.
- `dice_val` in 3: roll value; only 1–6 are legal; sampled with `start`.
- `tile_idx_p0` out 4: current tile of P0.
- `tile_idx_p1` out 4: current tile of P1.
- `busy` out 1: move in progress.
- `done` out 1: one-cycle pulse when a move completes.
- `winner_valid` out 1: sticky; a token has landed on `LAST_TILE`.
- `winner` out 1: player that reached the goal; valid while `winner_valid` = 1.

## Operation
- States:
  - IDLE: waits for `start`.
  - HOP_WAIT: counts frame ticks.
  - STEP: moves the token one tile.
  - FINISH: emits `done`, evaluates win.
- IDLE → HOP_WAIT on `start` when `dice_val` ∈ 1..6 and `winner_valid` = 0.
  - Latch `player_sel` into `active`, `dice_val` into `remaining`.
  - Clear `tick_cnt` and set `dir` = forward.
- A `start` with an illegal `dice_val` (0 or 7), any `start` in a non-IDLE state, and any `start` while `winner_valid` = 1 are all ignored: no state or output change.
- HOP_WAIT: on each `frame_tick`, if `tick_cnt` = `STEP_FRAMES`−1, go to STEP and clear `tick_cnt`; otherwise increment `tick_cnt`.
- STEP, which lasts one cycle:
  - If forward and tile < `LAST_TILE`: tile += 1.
  - If forward and tile = `LAST_TILE`: handled per the Configuration section (overshoot).
  - If reverse: tile −= 1, with a floor at 0.
  - `remaining` −= 1. If `remaining` becomes 0, go to FINISH; otherwise go to HOP_WAIT.
- FINISH, which lasts one cycle:
  - `done` = 1.
  - If the active tile = `LAST_TILE`, set `winner_valid` = 1 and `winner` = `active`.
  - Then go to IDLE.
- Only the active token's tile changes. The other token's tile holds.
- Arithmetic: `tick_cnt` is 8 bit, `remaining` is 3 bit, tiles are 4 bit unsigned. No wrap-around is permitted.

## Timing
- Reset values: both tiles = 0, `busy` = 0, `done` = 0, `winner_valid` = 0, `winner` = 0, state = IDLE, all counters = 0.
- Reset mid-move aborts the move immediately. The reset values apply on the next edge and no `done` is emitted.
- `busy` = 1 from the cycle after `start` is accepted through the FINISH cycle inclusive. `busy` = 0 in IDLE.
- A `frame_tick` coincident with the accepting `start` cycle is not counted.
- The first hop is visible on the cycle after the `STEP_FRAMES`-th counted `frame_tick`.
- Each subsequent hop comes exactly `STEP_FRAMES` ticks after the previous one.
- `done` asserts one cycle after the final STEP.
- `winner_valid` rises in the same cycle as `done`.
- Tile outputs are registered and change only in the cycle following STEP.
- A `start` in the same cycle as `done` is ignored. `start` is accepted from the next cycle.

## Configuration
- `BOUNCE_BACK_EN` defined (overshoot rule):
  - At STEP with forward `dir` and tile = `LAST_TILE`, set `dir` = reverse and tile −= 1.
  - Remaining hops then continue in reverse.
  - The token wins only if it lands exactly on `LAST_TILE`.
- `BOUNCE_BACK_EN` undefined (overshoot rule):
  - At STEP with tile = `LAST_TILE`, the tile holds and `remaining` is forced to 0, going to FINISH. The early stop is a clamp.
  - The win is reported at FINISH.

## Test plan
- Reset; `STEP_FRAMES`=2; P0 rolls 3 with continuous ticks → `tile_idx_p0` steps 1, 2, 3, each exactly 2 ticks apart. `done` pulses once, 1 cycle after the last step. `tile_idx_p1` stays 0.
- P1 rolls 0, then 7, then P0 `start` mid-move → all ignored. `busy`/tiles are unchanged beyond the in-flight move.
- P0 at tile 7 rolls 2 → tile 9. `winner_valid` = 1 and `winner` = 0, asserted in the `done` cycle. A later `start` of 4 is ignored.
- P1 at tile 8 rolls 4:
  - Without `BOUNCE_BACK_EN`: the tile clamps at 9 after 1 hop, then `done`, and the win is set.
  - With `BOUNCE_BACK_EN`: the tile goes 9, 8, 7, 6. There is no win.
- `reset` asserted during HOP_WAIT of a 6-roll → next cycle both tiles = 0, `busy` = 0, no `done`. A new `start` is accepted afterwards.
- `start` with a coincident `frame_tick`, `STEP_FRAMES`=1 → the first hop follows the next tick, not the coincident one.
